// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: builds one cache line from refill beats and writes it to
// port 0 of the 1R1W data SRAM. It also gates lookups onto port 1 and keeps the
// per-line valid bitmap that goes back with every read response.
module icache_fill_ctrl #(
  parameter int LINE_WIDTH = 320,
  parameter int BEAT_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // refill request
  input  logic                  fill_req_valid,
  output logic                  fill_req_ready,
  input  logic [ADDR_WIDTH-1:0] fill_req_index,
  // refill data beats
  input  logic                  beat_valid,
  output logic                  beat_ready,
  input  logic [BEAT_WIDTH-1:0] beat_data,
  // fill completion
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] fill_done_index,
  input  logic                  invalidate_all,
  // lookups
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_req_index,
  output logic                  rd_resp_valid,
  output logic [ADDR_WIDTH-1:0] rd_resp_index,
  output logic                  rd_resp_hit,
  // SRAM port 0 (write) and port 1 (read)
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [LINE_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS + 1) : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [LINE_WIDTH-1:0]   line_buf_q, line_buf_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic                    rd_resp_valid_q;
  logic [ADDR_WIDTH-1:0]   rd_resp_index_q;
  logic                    rd_resp_hit_q;

  logic                    rd_hazard;
  logic                    rd_fire;

  // Fill state, beat counter, latched index and line buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      line_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      line_buf_q <= line_buf_d;
    end
  end

  // Fill sequencing: next state, beat capture and handshake/strobe outputs
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    line_buf_d     = line_buf_q;
    fill_req_ready = 1'b0;
    beat_ready     = 1'b0;
    sram_csb0      = 1'b1;
    fill_done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        fill_req_ready = 1'b1;
        if (fill_req_valid) begin
          idx_d   = fill_req_index;
          cnt_d   = '0;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        beat_ready = 1'b1;
        if (beat_valid) begin
          // beat 0 lands in the least-significant slice of the line
          line_buf_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = beat_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        sram_csb0 = 1'b0;
        state_d   = S_DONE;
      end
      S_DONE: begin
        fill_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Port-0 address/data simply follow the latched index and buffer
  assign sram_addr0      = idx_q;
  assign sram_din0       = line_buf_q;
  assign fill_done_index = idx_q;

  // Valid bitmap update; a simultaneous invalidate overrides the DONE set
  always_comb begin
    valid_d = valid_q;
    if (state_q == S_DONE) begin
      valid_d[idx_q] = 1'b1;
    end
    if (invalidate_all) begin
      valid_d = '0;
    end
  end

  // Valid bitmap register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // A read to the line being written is held off through WRITE and DONE so
  // that it cannot race the SRAM's negedge commit of the new line.
  assign rd_hazard    = ((state_q == S_WRITE) || (state_q == S_DONE)) &&
                        (rd_req_index == idx_q);
  assign rd_req_ready = ~rd_hazard;
  assign rd_fire      = rd_req_valid & rd_req_ready;
  assign sram_csb1    = ~rd_fire;
  assign sram_addr1   = rd_req_index;

  // Read response pipeline: one cycle after acceptance, alongside SRAM dout1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_valid_q <= 1'b0;
      rd_resp_index_q <= '0;
      rd_resp_hit_q   <= 1'b0;
    end else begin
      rd_resp_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_resp_index_q <= rd_req_index;
        rd_resp_hit_q   <= valid_q[rd_req_index];
      end
    end
  end

  assign rd_resp_valid = rd_resp_valid_q;
  assign rd_resp_index = rd_resp_index_q;
  assign rd_resp_hit   = rd_resp_hit_q;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Testbench for icache_fill_ctrl: directed fills from the test plan followed
// by randomized traffic, all checked against a timeline-based reference model.
module tb_icache_fill_ctrl;

  localparam int LW    = 320;
  localparam int BW    = 32;
  localparam int AW    = 4;
  localparam int BEATS = LW / BW;

  logic          clk;
  logic          rst_n;
  logic          fill_req_valid;
  logic          fill_req_ready;
  logic [AW-1:0] fill_req_index;
  logic          beat_valid;
  logic          beat_ready;
  logic [BW-1:0] beat_data;
  logic          fill_done;
  logic [AW-1:0] fill_done_index;
  logic          invalidate_all;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_index;
  logic          rd_resp_valid;
  logic [AW-1:0] rd_resp_index;
  logic          rd_resp_hit;
  logic          sram_csb0;
  logic [AW-1:0] sram_addr0;
  logic [LW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;

  icache_fill_ctrl #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fill_req_valid  (fill_req_valid),
    .fill_req_ready  (fill_req_ready),
    .fill_req_index  (fill_req_index),
    .beat_valid      (beat_valid),
    .beat_ready      (beat_ready),
    .beat_data       (beat_data),
    .fill_done       (fill_done),
    .fill_done_index (fill_done_index),
    .invalidate_all  (invalidate_all),
    .rd_req_valid    (rd_req_valid),
    .rd_req_ready    (rd_req_ready),
    .rd_req_index    (rd_req_index),
    .rd_resp_valid   (rd_resp_valid),
    .rd_resp_index   (rd_resp_index),
    .rd_resp_hit     (rd_resp_hit),
    .sram_csb0       (sram_csb0),
    .sram_addr0      (sram_addr0),
    .sram_din0       (sram_din0),
    .sram_csb1       (sram_csb1),
    .sram_addr1      (sram_addr1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a fill is a timeline. Once the last beat is accepted at
  // cycle c, the SRAM write happens at c+1 and the done pulse at c+2.
  int            cyc = 0;
  bit            busy = 0;
  int            acc_cyc = 0;
  int            beats = 0;
  logic [AW-1:0] f_idx = '0;
  logic [LW-1:0] f_line = '0;
  int            wr_cyc = -1;
  int            dn_cyc = -1;
  int            last_done_cyc = -1000;
  bit            exp_valid [16];
  bit            rsp_pend = 0;
  logic [AW-1:0] rsp_idx = '0;
  bit            rsp_hit = 0;

  task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    busy     = 0;
    beats    = 0;
    wr_cyc   = -1;
    dn_cyc   = -1;
    rsp_pend = 0;
    foreach (exp_valid[i]) exp_valid[i] = 0;
  endtask

  task automatic idle_inputs();
    fill_req_valid = 1'b0;
    fill_req_index = '0;
    beat_valid     = 1'b0;
    beat_data      = '0;
    invalidate_all = 1'b0;
    rd_req_valid   = 1'b0;
    rd_req_index   = '0;
  endtask

  // Called just after a negedge with inputs already driven: checks the DUT
  // against the model for this cycle, then advances both across the posedge.
  task automatic tick();
    bit            e_frr, e_br, e_wr, e_dn, haz, fire;
    bit            n_pend, n_hit;
    logic [AW-1:0] n_idx;
    #1;
    e_frr = !busy;
    e_br  = busy && (beats < BEATS);
    e_wr  = (cyc == wr_cyc);
    e_dn  = (cyc == dn_cyc);
    haz   = (e_wr || e_dn) && (rd_req_index == f_idx);
    fire  = rd_req_valid && !haz;
    check_eq("fill_req_ready", LW'(fill_req_ready), LW'(e_frr));
    check_eq("beat_ready", LW'(beat_ready), LW'(e_br));
    check_eq("sram_csb0", LW'(sram_csb0), LW'(!e_wr));
    check_eq("fill_done", LW'(fill_done), LW'(e_dn));
    check_eq("rd_req_ready", LW'(rd_req_ready), LW'(!haz));
    check_eq("sram_csb1", LW'(sram_csb1), LW'(!fire));
    check_eq("sram_addr1", LW'(sram_addr1), LW'(rd_req_index));
    if (e_wr) begin
      check_eq("sram_addr0", LW'(sram_addr0), LW'(f_idx));
      check_eq("sram_din0", sram_din0, f_line);
    end
    if (e_dn) check_eq("fill_done_index", LW'(fill_done_index), LW'(f_idx));
    if (fill_done) last_done_cyc = cyc;
    check_eq("rd_resp_valid", LW'(rd_resp_valid), LW'(rsp_pend));
    if (rsp_pend) begin
      check_eq("rd_resp_index", LW'(rd_resp_index), LW'(rsp_idx));
      check_eq("rd_resp_hit", LW'(rd_resp_hit), LW'(rsp_hit));
    end
    n_pend = fire;
    n_idx  = rd_req_index;
    n_hit  = exp_valid[rd_req_index];
    @(posedge clk);
    if (!busy && fill_req_valid) begin
      busy    = 1;
      f_idx   = fill_req_index;
      beats   = 0;
      acc_cyc = cyc;
      wr_cyc  = -1;
      dn_cyc  = -1;
    end else if (e_br && beat_valid) begin
      f_line[beats*BW +: BW] = beat_data;
      beats++;
      if (beats == BEATS) begin
        wr_cyc = cyc + 1;
        dn_cyc = cyc + 2;
      end
    end
    if (e_dn) begin
      busy = 0;
      exp_valid[f_idx] = 1;
    end
    if (invalidate_all) foreach (exp_valid[i]) exp_valid[i] = 0;
    rsp_pend = n_pend;
    rsp_idx  = n_idx;
    rsp_hit  = n_hit;
    cyc++;
    @(negedge clk);
  endtask

  // Asserts reset just after a negedge, checks the immediate (asynchronous)
  // effect, and releases it at the following negedge.
  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    check_eq("rst_csb0", LW'(sram_csb0), LW'(1));
    check_eq("rst_fill_req_ready", LW'(fill_req_ready), LW'(1));
    check_eq("rst_beat_ready", LW'(beat_ready), LW'(0));
    check_eq("rst_fill_done", LW'(fill_done), LW'(0));
    check_eq("rst_rd_resp_valid", LW'(rd_resp_valid), LW'(0));
    check_eq("rst_rd_resp_hit", LW'(rd_resp_hit), LW'(0));
    check_eq("rst_rd_resp_index", LW'(rd_resp_index), LW'(0));
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    fill_req_valid = 1'b0;
    beat_valid     = 1'b1;
    beat_data      = 32'hdead_beef;
    invalidate_all = 1'b0;
    while (busy && g < 64) begin
      tick();
      g++;
    end
    check_eq("drain_bound", LW'(g < 64), LW'(1));
  endtask

  // Directed fill: beats carry their own beat number; optional beat_valid gap
  // after beat gap_at, optional invalidate in DONE, optional reset once
  // stop_at beats have been accepted (stop_at == BEATS lands in WRITE).
  task automatic run_fill(input logic [AW-1:0] idx, input int gap_at, input int gap_len,
                          input bit inval_done, input bit rd_on, input logic [AW-1:0] rd_idx,
                          input int stop_at);
    int guard;
    int gap_left;
    guard          = 0;
    gap_left       = gap_len;
    last_done_cyc  = -1000;
    fill_req_valid = 1'b1;
    fill_req_index = idx;
    beat_valid     = 1'b0;
    invalidate_all = 1'b0;
    rd_req_valid   = rd_on;
    rd_req_index   = rd_idx;
    tick();
    fill_req_valid = 1'b0;
    while (busy && guard < 100) begin
      if (stop_at != 0 && beats == stop_at) begin
        if (stop_at == BEATS) begin
          #1;
          check_eq("csb0_before_reset", LW'(sram_csb0), LW'(0));
        end
        reset_now();
        $display("[TB] fill idx %0d interrupted by reset after %0d beats", idx, stop_at);
        return;
      end
      beat_valid = 1'b1;
      if (beats == gap_at && gap_left > 0) begin
        beat_valid = 1'b0;
        gap_left--;
      end
      beat_data      = BW'(beats);
      invalidate_all = inval_done && (cyc == dn_cyc);
      tick();
      guard++;
    end
    invalidate_all = 1'b0;
    beat_valid     = 1'b0;
    check_eq("fill_bound", LW'(guard < 100), LW'(1));
    check_eq("fill_latency", LW'(last_done_cyc - acc_cyc), LW'(12 + gap_len));
    $display("[TB] fill idx %0d committed, accept->done %0d cycles", idx, last_done_cyc - acc_cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #2;
    check_eq("init_csb0", LW'(sram_csb0), LW'(1));
    check_eq("init_fill_req_ready", LW'(fill_req_ready), LW'(1));
    check_eq("init_beat_ready", LW'(beat_ready), LW'(0));
    check_eq("init_fill_done", LW'(fill_done), LW'(0));
    check_eq("init_rd_resp_valid", LW'(rd_resp_valid), LW'(0));
    check_eq("init_rd_resp_hit", LW'(rd_resp_hit), LW'(0));
    check_eq("init_rd_resp_index", LW'(rd_resp_index), LW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // basic fill of index 3 with a same-index read held throughout
    run_fill(4'd3, 99, 0, 1'b0, 1'b1, 4'd3, 0);
    tick();
    #1;
    check_eq("post_fill_hit3", LW'(rd_resp_hit), LW'(1));

    // non-colliding read to index 5 across the whole fill
    run_fill(4'd9, 99, 0, 1'b0, 1'b1, 4'd5, 0);
    // beat_valid gap of 4 cycles after beat 4
    run_fill(4'd11, 4, 4, 1'b0, 1'b0, 4'd0, 0);
    // invalidate racing the DONE cycle
    run_fill(4'd7, 99, 0, 1'b1, 1'b1, 4'd7, 0);
    tick();
    #1;
    check_eq("inval_race_hit7", LW'(rd_resp_hit), LW'(0));

    // reset after beat 6, then confirm the bitmap is empty and refill works
    rd_req_valid = 1'b0;
    run_fill(4'd2, 99, 0, 1'b0, 1'b0, 4'd0, 6);
    rd_req_valid = 1'b1;
    rd_req_index = 4'd3;
    tick();
    #1;
    check_eq("post_rst_hit3", LW'(rd_resp_hit), LW'(0));
    run_fill(4'd4, 99, 0, 1'b0, 1'b1, 4'd4, 0);
    tick();
    #1;
    check_eq("post_rst_fill_hit4", LW'(rd_resp_hit), LW'(1));

    // reset while the write strobe is active
    run_fill(4'd6, 99, 0, 1'b0, 1'b0, 4'd0, BEATS);

    // randomized concurrent traffic
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) reset_now();
      fill_req_valid = ($urandom % 4) == 0;
      fill_req_index = AW'($urandom);
      beat_valid     = ($urandom % 3) != 0;
      beat_data      = $urandom;
      rd_req_valid   = ($urandom % 2) == 0;
      rd_req_index   = (($urandom % 2) == 0) ? f_idx : AW'($urandom);
      invalidate_all = ($urandom % 50) == 0;
      tick();
    end
    drain();
    rd_req_valid = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
